// File: rtl/prbs_gen_chk_if.sv
// -----------------------------------------------------------------------------
// prbs_gen_chk_if
// Bundle of the PRBS generator/checker control and data signals.
//   master : drives poly_sel, gen_en, inject_err, chk_data, chk_valid,
//            clear_count; observes gen_data, gen_valid, lock, bit_error,
//            err_count.
//   slave  : the prbs_gen_chk block itself (mirror of master).
// Parameters WIDTH and ERRCNT_W must match the attached prbs_gen_chk.
// -----------------------------------------------------------------------------
interface prbs_gen_chk_if #(
   parameter int WIDTH    = 8,
   parameter int ERRCNT_W = 16
);
   logic [1:0]          poly_sel;
   logic                gen_en;
   logic                inject_err;
   logic [WIDTH-1:0]    gen_data;
   logic                gen_valid;
   logic [WIDTH-1:0]    chk_data;
   logic                chk_valid;
   logic                clear_count;
   logic                lock;
   logic                bit_error;
   logic [ERRCNT_W-1:0] err_count;

   modport master (
      output poly_sel, gen_en, inject_err, chk_data, chk_valid, clear_count,
      input  gen_data, gen_valid, lock, bit_error, err_count
   );

   modport slave (
      input  poly_sel, gen_en, inject_err, chk_data, chk_valid, clear_count,
      output gen_data, gen_valid, lock, bit_error, err_count
   );
endinterface

// File: rtl/prbs_gen_chk.sv
// -----------------------------------------------------------------------------
// prbs_gen_chk
// WIDTH-bit-per-clock PRBS generator and self-synchronising PRBS checker with
// a lock FSM and a saturating mismatch counter.
// Polynomials (poly_sel): 0 PRBS7, 1 PRBS15, 2 PRBS23, 3 PRBS31.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : prbs_gen_chk_if.slave
//          in  poly_sel, gen_en, inject_err, chk_data, chk_valid, clear_count
//          out gen_data, gen_valid, lock, bit_error, err_count (all registered)
// Bit order: bit WIDTH-1 of a word is the earliest bit in time.
// -----------------------------------------------------------------------------
module prbs_gen_chk #(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 4,
   parameter int ERRCNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   prbs_gen_chk_if.slave bus
);

   localparam int PC_W  = $clog2(WIDTH + 1);
   localparam int LC_W  = $clog2(LOCK_CNT + 1);
   localparam int SC_W  = $clog2(LOSS_CNT + 1);
   localparam int SUM_W = ((ERRCNT_W > PC_W) ? ERRCNT_W : PC_W) + 1;
   localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   // Feedback bit of the selected polynomial for a 31-bit shift state.
   function automatic logic tap_fb(input logic [30:0] s, input logic [1:0] poly);
      logic fb;
      case (poly)
         2'd0:    fb = s[6]  ^ s[5];
         2'd1:    fb = s[14] ^ s[13];
         2'd2:    fb = s[22] ^ s[17];
         2'd3:    fb = s[30] ^ s[27];
         default: fb = s[6]  ^ s[5];
      endcase
      return fb;
   endfunction

   // Number of set bits in a mismatch word.
   function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [PC_W-1:0] n;
      n = {PC_W{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         n = n + PC_W'(v[i]);
      end
      return n;
   endfunction

   logic [1:0]          poly_r;
   logic                poly_chg_s;
   logic [30:0]         lfsr_r;
   logic [30:0]         gen_state_s;
   logic [WIDTH-1:0]    gen_word_s;
   logic                gen_bit_s;
   logic [WIDTH-1:0]    gen_data_r;
   logic                gen_valid_r;
   logic [30:0]         hist_r;
   logic [30:0]         hist_s;
   logic                pred_bit_s;
   logic [WIDTH-1:0]    mism_s;
   logic [PC_W-1:0]     pop_s;
   logic                word_err_s;
   logic [SUM_W-1:0]    sum_s;
   logic                bit_error_r;
   state_t              state_r;
   state_t              state_nx;
   logic [LC_W-1:0]     lock_cnt_r;
   logic [LC_W-1:0]     lock_cnt_nx;
   logic [SC_W-1:0]     loss_cnt_r;
   logic [SC_W-1:0]     loss_cnt_nx;
   logic                lock_r;
   logic [ERRCNT_W-1:0] err_count_r;

   // The polynomial register doubles as the change detector: a differing
   // input means the user just switched polynomials.
   assign poly_chg_s = (bus.poly_sel != poly_r);

   // Generator: run the LFSR WIDTH bit-steps ahead, earliest bit to MSB.
   always_comb begin
      gen_state_s = lfsr_r;
      gen_word_s  = {WIDTH{1'b0}};
      gen_bit_s   = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         gen_bit_s                = tap_fb(gen_state_s, poly_r);
         gen_word_s[WIDTH-1-i]    = gen_bit_s;
         gen_state_s              = {gen_state_s[29:0], gen_bit_s};
      end
   end

   // Checker: predict each received bit from the history of received bits,
   // then push the received (not predicted) bit so errors self-flush.
   always_comb begin
      hist_s     = hist_r;
      mism_s     = {WIDTH{1'b0}};
      pred_bit_s = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         pred_bit_s            = tap_fb(hist_s, poly_r);
         mism_s[WIDTH-1-i]     = bus.chk_data[WIDTH-1-i] ^ pred_bit_s;
         hist_s                = {hist_s[29:0], bus.chk_data[WIDTH-1-i]};
      end
   end

   // Mismatch statistics of the current word and the widened counter sum.
   always_comb begin
      pop_s      = popcount(mism_s);
      word_err_s = |mism_s;
      sum_s      = SUM_W'(err_count_r) + SUM_W'(pop_s);
   end

   // Generator state, output word and polynomial register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         poly_r      <= 2'd0;
         lfsr_r      <= {31{1'b1}};
         gen_data_r  <= {WIDTH{1'b0}};
         gen_valid_r <= 1'b0;
      end else begin
         poly_r <= bus.poly_sel;
         if (poly_chg_s) begin
            lfsr_r      <= {31{1'b1}};
            gen_valid_r <= 1'b0;
         end else if (bus.gen_en) begin
            lfsr_r      <= gen_state_s;
            // Corruption touches only the output word, never the LFSR.
            gen_data_r  <= gen_word_s ^ WIDTH'(bus.inject_err);
            gen_valid_r <= 1'b1;
         end else begin
            gen_valid_r <= 1'b0;
         end
      end
   end

   // Checker history and per-word error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_r      <= 31'd0;
         bit_error_r <= 1'b0;
      end else begin
         if (bus.chk_valid) begin
            hist_r <= hist_s;
         end
         bit_error_r <= bus.chk_valid & word_err_s;
      end
   end

   // Lock FSM next state and lock/loss run-length counters.
   always_comb begin
      state_nx    = state_r;
      lock_cnt_nx = lock_cnt_r;
      loss_cnt_nx = loss_cnt_r;
      if (poly_chg_s) begin
         state_nx    = SEARCH;
         lock_cnt_nx = {LC_W{1'b0}};
         loss_cnt_nx = {SC_W{1'b0}};
      end else if (bus.chk_valid) begin
         case (state_r)
            SEARCH: begin
               if (word_err_s) begin
                  lock_cnt_nx = {LC_W{1'b0}};
               end else if (lock_cnt_r == LC_W'(LOCK_CNT - 1)) begin
                  state_nx    = LOCKED;
                  lock_cnt_nx = {LC_W{1'b0}};
                  loss_cnt_nx = {SC_W{1'b0}};
               end else begin
                  lock_cnt_nx = lock_cnt_r + LC_W'(1'b1);
               end
            end
            LOCKED: begin
               if (!word_err_s) begin
                  loss_cnt_nx = {SC_W{1'b0}};
               end else if (loss_cnt_r == SC_W'(LOSS_CNT - 1)) begin
                  state_nx    = SEARCH;
                  loss_cnt_nx = {SC_W{1'b0}};
                  lock_cnt_nx = {LC_W{1'b0}};
               end else begin
                  loss_cnt_nx = loss_cnt_r + SC_W'(1'b1);
               end
            end
            default: begin
               state_nx    = SEARCH;
               lock_cnt_nx = {LC_W{1'b0}};
               loss_cnt_nx = {SC_W{1'b0}};
            end
         endcase
      end else begin
         state_nx = state_r;
      end
   end

   // Lock FSM state register and registered lock output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= SEARCH;
         lock_cnt_r <= {LC_W{1'b0}};
         loss_cnt_r <= {SC_W{1'b0}};
         lock_r     <= 1'b0;
      end else begin
         state_r    <= state_nx;
         lock_cnt_r <= lock_cnt_nx;
         loss_cnt_r <= loss_cnt_nx;
         lock_r     <= (state_nx == LOCKED);
      end
   end

   // Saturating error counter; counts in LOCKED including the word that
   // drops lock, since state_r is still LOCKED for that word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_r <= {ERRCNT_W{1'b0}};
      end else if (bus.clear_count) begin
         err_count_r <= {ERRCNT_W{1'b0}};
      end else if (!poly_chg_s && bus.chk_valid && (state_r == LOCKED)) begin
         if (sum_s > SUM_W'(ERR_MAX)) begin
            err_count_r <= ERR_MAX;
         end else begin
            err_count_r <= sum_s[ERRCNT_W-1:0];
         end
      end
   end

   assign bus.gen_data  = gen_data_r;
   assign bus.gen_valid = gen_valid_r;
   assign bus.bit_error = bit_error_r;
   assign bus.lock      = lock_r;
   assign bus.err_count = err_count_r;

endmodule
